// File: rtl/kp_voice_bank_if.sv
// Control and audio-path bundle for the Karplus-Strong voice bank.
// The master drives triggers and audio-rate inputs; the slave returns the mix and status.
interface kp_voice_bank_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 11,
    parameter int VOICES = 4,
    parameter int GAIN_W = 12
);
    logic                     sample_en;
    logic                     trig;
    logic [6:0]               velocity;
    logic [ADDR_W-1:0]        delay_len;
    logic [GAIN_W-1:0]        decay;
    logic [1:0]               filt_mode;
    logic signed [DATA_W-1:0] noise;
    logic signed [DATA_W-1:0] mix_out;
    logic                     mix_valid;
    logic [VOICES-1:0]        voice_active;
    logic                     overrun;

    modport master (
        output sample_en, trig, velocity, delay_len, decay, filt_mode, noise,
        input  mix_out, mix_valid, voice_active, overrun
    );

    modport slave (
        input  sample_en, trig, velocity, delay_len, decay, filt_mode, noise,
        output mix_out, mix_valid, voice_active, overrun
    );
endinterface

// File: rtl/kp_voice_bank.sv
// Polyphonic Karplus-Strong string engine: time-multiplexed voices share one delay RAM,
// each with its own tuning, burst load, loop filter, decay and silence detection.
module kp_voice_bank #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 11,
    parameter int VOICES     = 4,
    parameter int GAIN_W     = 12,
    parameter int SILENCE_TH = 256
) (
    input  logic              audio_clk_i,
    input  logic              reset_i,
    kp_voice_bank_if.slave    bus
);
    localparam int VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int DEPTH = VOICES << ADDR_W;
    localparam int ACC_W = DATA_W + VW;

    localparam logic signed [ACC_W-1:0]  MAX_V = {{(VW + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  MIN_V = {{(VW + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
    localparam logic signed [DATA_W-1:0] TH_P  = DATA_W'(SILENCE_TH);
    localparam logic signed [DATA_W-1:0] TH_N  = -TH_P;

    typedef enum logic [2:0] {F_WAIT, F_RD, F_CALC, F_WR, F_SUM} fstate_t;
    typedef enum logic [1:0] {V_IDLE, V_LOAD, V_RING} vstate_t;

    fstate_t          fst_q, fst_d;
    logic [VW-1:0]    v_q, v_d;
    logic             frame_start;
    logic             overrun_set;

    // Pending trigger and round-robin allocation
    logic             pend_v_q;
    logic [6:0]       pend_vel_q;
    logic [ADDR_W-1:0] pend_len_q;
    logic [VW-1:0]    rr_q;
    logic             consume;
    logic [ADDR_W-1:0] len_c;

    // Per-voice state
    vstate_t                  vst_q   [VOICES];
    logic [ADDR_W-1:0]        len_q   [VOICES];
    logic [ADDR_W-1:0]        ptr_q   [VOICES];
    logic [ADDR_W-1:0]        cnt_q   [VOICES];
    logic [ADDR_W-1:0]        quiet_q [VOICES];
    logic [6:0]               vel_q   [VOICES];
    logic signed [DATA_W-1:0] p1_q    [VOICES];
    logic signed [DATA_W-1:0] p2_q    [VOICES];

    // Datapath
    logic signed [DATA_W-1:0] ram [DEPTH];
    logic signed [DATA_W-1:0] ram_q;
    logic [VW+ADDR_W-1:0]     ram_addr;
    logic signed [DATA_W-1:0] w_q;
    logic signed [DATA_W-1:0] calc_w;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  w_ext;
    logic [DATA_W-1:0]        sat;
    logic [VOICES-1:0]        act_vec;
    logic                     voice_wr;

    vstate_t           cur_st, st_d;
    logic [ADDR_W-1:0] cur_len, cur_ptr, cur_cnt, cur_quiet;
    logic [ADDR_W-1:0] ptr_d, cnt_d, quiet_d;
    logic              quiet_w;

    logic signed [DATA_W+7:0]      load_prod;
    logic signed [DATA_W+1:0]      x_e, p1_e, p2_e, fsum;
    logic signed [DATA_W-1:0]      y;
    logic signed [DATA_W+GAIN_W:0] ring_prod;

    logic signed [DATA_W-1:0] mix_out_q;
    logic                     mix_valid_q;
    logic [VOICES-1:0]        voice_active_q;
    logic                     overrun_q;

    // ---------------- frame sequencer ----------------
    always_ff @(posedge audio_clk_i or posedge reset_i) begin
        if (reset_i) begin
            fst_q <= F_WAIT;
            v_q   <= '0;
        end else begin
            fst_q <= fst_d;
            v_q   <= v_d;
        end
    end

    always_comb begin
        fst_d       = fst_q;
        v_d         = v_q;
        frame_start = 1'b0;
        overrun_set = bus.sample_en && (fst_q != F_WAIT);
        case (fst_q)
            F_WAIT: begin
                if (bus.sample_en) begin
                    fst_d       = F_RD;
                    v_d         = '0;
                    frame_start = 1'b1;
                end
            end
            F_RD:   fst_d = F_CALC;
            F_CALC: fst_d = F_WR;
            F_WR: begin
                if (v_q == VW'(VOICES - 1)) begin
                    fst_d = F_SUM;
                end else begin
                    fst_d = F_RD;
                    v_d   = v_q + VW'(1);
                end
            end
            F_SUM:   fst_d = F_WAIT;
            default: fst_d = F_WAIT;
        endcase
    end

    // ---------------- trigger capture ----------------
    assign consume = frame_start && pend_v_q;
    assign len_c   = (pend_len_q < ADDR_W'(2)) ? ADDR_W'(2) : pend_len_q;

    // A trig in the frame-start cycle re-arms pending after the old one is consumed.
    always_ff @(posedge audio_clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_v_q   <= 1'b0;
            pend_vel_q <= '0;
            pend_len_q <= '0;
            rr_q       <= '0;
        end else begin
            if (consume) rr_q <= rr_q + VW'(1);
            if (bus.trig) begin
                pend_v_q   <= 1'b1;
                pend_vel_q <= bus.velocity;
                pend_len_q <= bus.delay_len;
            end else if (frame_start) begin
                pend_v_q   <= 1'b0;
            end
        end
    end

    // ---------------- current-voice arithmetic ----------------
    assign cur_st    = vst_q[v_q];
    assign cur_len   = len_q[v_q];
    assign cur_ptr   = ptr_q[v_q];
    assign cur_cnt   = cnt_q[v_q];
    assign cur_quiet = quiet_q[v_q];
    assign ram_addr  = {v_q, cur_ptr};
    assign voice_wr  = (fst_q == F_WR) && (cur_st != V_IDLE);

    assign load_prod = bus.noise * $signed({1'b0, vel_q[v_q]});
    assign x_e       = ram_q;
    assign p1_e      = p1_q[v_q];
    assign p2_e      = p2_q[v_q];

    always_comb begin
        fsum = x_e;
        case (bus.filt_mode)
            2'd0:    fsum = x_e;
            2'd2:    fsum = (x_e + (p1_e <<< 1) + p2_e) >>> 2;
            default: fsum = (x_e + p1_e) >>> 1;
        endcase
    end

    assign y         = DATA_W'(fsum);
    assign ring_prod = y * $signed({1'b0, bus.decay});
    assign calc_w    = (cur_st == V_LOAD) ? DATA_W'(load_prod >>> 7)
                                          : DATA_W'(ring_prod >>> GAIN_W);

    assign quiet_w = (w_q < TH_P) && (w_q > TH_N);

    always_comb begin
        st_d    = cur_st;
        cnt_d   = cur_cnt;
        quiet_d = cur_quiet;
        ptr_d   = (cur_ptr == cur_len - ADDR_W'(1)) ? '0 : cur_ptr + ADDR_W'(1);
        if (cur_st == V_LOAD) begin
            cnt_d = cur_cnt + ADDR_W'(1);
            if (cur_cnt == cur_len - ADDR_W'(1)) st_d = V_RING;
        end else if (cur_st == V_RING) begin
            quiet_d = quiet_w ? cur_quiet + ADDR_W'(1) : '0;
            if (quiet_w && (quiet_d == cur_len)) st_d = V_IDLE;
        end
    end

    // ---------------- per-voice registers ----------------
    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_voice
            always_ff @(posedge audio_clk_i or posedge reset_i) begin
                if (reset_i) begin
                    vst_q[gi]   <= V_IDLE;
                    len_q[gi]   <= '0;
                    ptr_q[gi]   <= '0;
                    cnt_q[gi]   <= '0;
                    quiet_q[gi] <= '0;
                    vel_q[gi]   <= '0;
                    p1_q[gi]    <= '0;
                    p2_q[gi]    <= '0;
                end else if (consume && (rr_q == VW'(gi))) begin
                    vst_q[gi]   <= V_LOAD;
                    len_q[gi]   <= len_c;
                    ptr_q[gi]   <= '0;
                    cnt_q[gi]   <= '0;
                    quiet_q[gi] <= '0;
                    vel_q[gi]   <= pend_vel_q;
                    p1_q[gi]    <= '0;
                    p2_q[gi]    <= '0;
                end else if (voice_wr && (v_q == VW'(gi))) begin
                    vst_q[gi]   <= st_d;
                    ptr_q[gi]   <= ptr_d;
                    cnt_q[gi]   <= cnt_d;
                    quiet_q[gi] <= quiet_d;
                    if (cur_st == V_RING) begin
                        p2_q[gi] <= p1_q[gi];
                        p1_q[gi] <= ram_q;
                    end
                end
            end
            assign act_vec[gi] = (vst_q[gi] != V_IDLE);
        end
    endgenerate

    // ---------------- delay RAM (contents survive reset) ----------------
    always_ff @(posedge audio_clk_i) begin
        if (fst_q == F_RD) ram_q <= ram[ram_addr];
        if (voice_wr)      ram[ram_addr] <= w_q;
    end

    // ---------------- mix and outputs ----------------
    assign w_ext = w_q;

    always_comb begin
        if (acc_q > MAX_V)      sat = {1'b0, {(DATA_W - 1){1'b1}}};
        else if (acc_q < MIN_V) sat = {1'b1, {(DATA_W - 1){1'b0}}};
        else                    sat = acc_q[DATA_W-1:0];
    end

    always_ff @(posedge audio_clk_i or posedge reset_i) begin
        if (reset_i) begin
            w_q            <= '0;
            acc_q          <= '0;
            mix_out_q      <= '0;
            mix_valid_q    <= 1'b0;
            voice_active_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            if (fst_q == F_CALC) w_q <= calc_w;
            if (frame_start)     acc_q <= '0;
            else if (voice_wr)   acc_q <= acc_q + w_ext;
            mix_valid_q <= (fst_q == F_SUM);
            if (fst_q == F_SUM) begin
                mix_out_q      <= sat;
                voice_active_q <= act_vec;
            end
            if (overrun_set) overrun_q <= 1'b1;
        end
    end

    assign bus.mix_out      = mix_out_q;
    assign bus.mix_valid    = mix_valid_q;
    assign bus.voice_active = voice_active_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_kp_voice_bank.sv
// Directed-vector bench for kp_voice_bank: one task per scenario, hand-computed expectations.
`timescale 1ns/1ps
module tb_kp_voice_bank;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 11;
    localparam int VOICES = 4;
    localparam int GAIN_W = 12;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    kp_voice_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VOICES(VOICES), .GAIN_W(GAIN_W)) bus ();

    kp_voice_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VOICES(VOICES), .GAIN_W(GAIN_W),
                    .SILENCE_TH(256)) dut (
        .audio_clk_i (clk),
        .reset_i     (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        bus.sample_en = 1'b0;
        bus.trig      = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts one frame (optionally with a coincident trig) and waits for its mix_valid.
    task automatic run_frame(input logic tg, input logic [6:0] vel, input logic [ADDR_W-1:0] len);
        int lat;
        @(negedge clk);
        bus.sample_en = 1'b1;
        bus.trig      = tg;
        bus.velocity  = vel;
        bus.delay_len = len;
        @(negedge clk);
        bus.sample_en = 1'b0;
        bus.trig      = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (bus.mix_valid === 1'b1) lat = n;
        end
        checks++;
        if (lat != 13) begin
            errors++;
            $display("FAIL frame_latency: got %0d cycles, expected 13 (0 = timeout)", lat);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_trig(input logic [6:0] vel, input logic [ADDR_W-1:0] len);
        @(negedge clk);
        bus.trig      = 1'b1;
        bus.velocity  = vel;
        bus.delay_len = len;
        @(negedge clk);
        bus.trig      = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus.mix_out !== 24'h0) begin errors++; $display("FAIL reset_mix: got %h expected 000000", bus.mix_out); end
        checks++;
        if (bus.mix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.mix_valid); end
        checks++;
        if (bus.voice_active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b expected 0000", bus.voice_active); end
        checks++;
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
        $display("test_reset done");
    endtask

    task automatic test_idle_frames();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0, 7'd0, 11'd0);
            checks++;
            if (bus.mix_out !== 24'h0) begin errors++; $display("FAIL idle_mix: got %h expected 000000", bus.mix_out); end
            checks++;
            if (bus.voice_active !== 4'b0000) begin errors++; $display("FAIL idle_active: got %b expected 0000", bus.voice_active); end
            $display("idle frame %0d mix=%h active=%b", f, bus.mix_out, bus.voice_active);
        end
    endtask

    // 0x100000*127>>7 = 0x0FE000; ring: 1040384*4095/4096 = 1040130 = 0x0FDF02.
    task automatic test_decay_ring();
        logic [23:0] exp_v;
        do_reset();
        bus.noise = 24'sh100000; bus.decay = 12'd4095; bus.filt_mode = 2'd0;
        pulse_trig(7'd127, 11'd100);
        for (int f = 1; f <= 102; f++) begin
            run_frame(1'b0, 7'd0, 11'd0);
            exp_v = (f <= 100) ? 24'h0FE000 : 24'h0FDF02;
            checks++;
            if (bus.mix_out !== exp_v) begin
                errors++;
                $display("FAIL decay_frame%0d: got %h expected %h", f, bus.mix_out, exp_v);
            end
            if (f == 1) begin
                checks++;
                if (bus.voice_active !== 4'b0001) begin errors++; $display("FAIL decay_active: got %b expected 0001", bus.voice_active); end
            end
        end
        $display("test_decay_ring last mix=%h", bus.mix_out);
    endtask

    // Voice contribution with noise 0x010000: vel 64 -> 0x8000, vel 127 -> 0xFE00.
    task automatic test_round_robin();
        do_reset();
        bus.noise = 24'sh010000; bus.decay = 12'd4095; bus.filt_mode = 2'd0;
        run_frame(1'b1, 7'd64, 11'd100);
        checks++;
        if (bus.voice_active !== 4'b0000) begin errors++; $display("FAIL rr_coincident: got %b expected 0000", bus.voice_active); end
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.voice_active !== 4'b0001 || bus.mix_out !== 24'h008000) begin
            errors++; $display("FAIL rr_v0: got %b/%h expected 0001/008000", bus.voice_active, bus.mix_out);
        end
        pulse_trig(7'd127, 11'd100);
        pulse_trig(7'd64, 11'd100);
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.voice_active !== 4'b0011 || bus.mix_out !== 24'h010000) begin
            errors++; $display("FAIL rr_overwrite: got %b/%h expected 0011/010000", bus.voice_active, bus.mix_out);
        end
        pulse_trig(7'd64, 11'd100);
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.voice_active !== 4'b0111 || bus.mix_out !== 24'h018000) begin
            errors++; $display("FAIL rr_v2: got %b/%h expected 0111/018000", bus.voice_active, bus.mix_out);
        end
        pulse_trig(7'd64, 11'd100);
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.voice_active !== 4'b1111 || bus.mix_out !== 24'h020000) begin
            errors++; $display("FAIL rr_v3: got %b/%h expected 1111/020000", bus.voice_active, bus.mix_out);
        end
        // Fifth trig wraps to voice 0: silent burst, len clamps to 2, idles after 2 quiet RING frames.
        pulse_trig(7'd0, 11'd1);
        for (int f = 1; f <= 4; f++) begin
            run_frame(1'b0, 7'd0, 11'd0);
            checks++;
            if (bus.mix_out !== 24'h018000) begin errors++; $display("FAIL rr_restart_mix%0d: got %h expected 018000", f, bus.mix_out); end
            checks++;
            if (bus.voice_active !== ((f == 4) ? 4'b1110 : 4'b1111)) begin
                errors++; $display("FAIL rr_restart_active%0d: got %b expected %b", f, bus.voice_active, (f == 4) ? 4'b1110 : 4'b1111);
            end
            $display("restart frame %0d mix=%h active=%b", f, bus.mix_out, bus.voice_active);
        end
    endtask

    // 0x7FFFFF*127>>7 = 0x7EFFFF; 0x800000*127>>7 = -8323072; 0xFFFFFF*127>>7 = -1 (floor).
    task automatic test_saturation();
        do_reset();
        bus.noise = 24'sh7FFFFF; bus.decay = 12'd4095; bus.filt_mode = 2'd0;
        for (int f = 1; f <= 4; f++) begin
            pulse_trig(7'd127, 11'd100);
            run_frame(1'b0, 7'd0, 11'd0);
            checks++;
            if (bus.mix_out !== ((f == 1) ? 24'h7EFFFF : 24'h7FFFFF)) begin
                errors++; $display("FAIL sat_pos%0d: got %h expected %h", f, bus.mix_out, (f == 1) ? 24'h7EFFFF : 24'h7FFFFF);
            end
        end
        bus.noise = 24'sh800000;
        for (int f = 1; f <= 2; f++) begin
            run_frame(1'b0, 7'd0, 11'd0);
            checks++;
            if (bus.mix_out !== 24'h800000) begin errors++; $display("FAIL sat_neg%0d: got %h expected 800000", f, bus.mix_out); end
        end
        bus.noise = 24'shFFFFFF;
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.mix_out !== 24'hFFFFFC) begin errors++; $display("FAIL floor_neg: got %h expected FFFFFC", bus.mix_out); end
        $display("test_saturation last mix=%h", bus.mix_out);
    endtask

    // x = 0x0FE000 (1040384), len 2, decay 2048 (x0.5).
    task automatic test_filter();
        do_reset();
        bus.noise = 24'sh100000; bus.decay = 12'd2048; bus.filt_mode = 2'd1;
        pulse_trig(7'd127, 11'd2);
        run_frame(1'b0, 7'd0, 11'd0);
        run_frame(1'b0, 7'd0, 11'd0);
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.mix_out !== 24'h03F800) begin errors++; $display("FAIL filt_m1: got %h expected 03F800", bus.mix_out); end
        bus.filt_mode = 2'd3;
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.mix_out !== 24'h07F000) begin errors++; $display("FAIL filt_m3: got %h expected 07F000", bus.mix_out); end
        do_reset();
        bus.filt_mode = 2'd2;
        pulse_trig(7'd127, 11'd2);
        run_frame(1'b0, 7'd0, 11'd0);
        run_frame(1'b0, 7'd0, 11'd0);
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.mix_out !== 24'h01FC00) begin errors++; $display("FAIL filt_m2a: got %h expected 01FC00", bus.mix_out); end
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.mix_out !== 24'h05F400) begin errors++; $display("FAIL filt_m2b: got %h expected 05F400", bus.mix_out); end
        $display("test_filter last mix=%h", bus.mix_out);
    endtask

    task automatic test_silence();
        do_reset();
        bus.noise = 24'sh100000; bus.decay = 12'd0; bus.filt_mode = 2'd0;
        pulse_trig(7'd127, 11'd10);
        for (int f = 1; f <= 20; f++) begin
            run_frame(1'b0, 7'd0, 11'd0);
            if (f == 10 || f == 11) begin
                checks++;
                if (bus.mix_out !== ((f == 10) ? 24'h0FE000 : 24'h000000)) begin
                    errors++; $display("FAIL silence_mix%0d: got %h expected %h", f, bus.mix_out, (f == 10) ? 24'h0FE000 : 24'h0);
                end
            end
            if (f >= 19) begin
                checks++;
                if (bus.voice_active !== ((f == 19) ? 4'b0001 : 4'b0000)) begin
                    errors++; $display("FAIL silence_active%0d: got %b expected %b", f, bus.voice_active, (f == 19) ? 4'b0001 : 4'b0000);
                end
            end
        end
        $display("test_silence active=%b", bus.voice_active);
    endtask

    task automatic test_overrun_and_abort();
        int lat;
        int seen;
        do_reset();
        bus.noise = 24'sh010000; bus.decay = 12'd4095; bus.filt_mode = 2'd0;
        @(negedge clk); bus.sample_en = 1'b1;
        @(negedge clk); bus.sample_en = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b expected 0", bus.overrun); end
        bus.sample_en = 1'b1;
        @(negedge clk); bus.sample_en = 1'b0;
        lat = 0;
        for (int n = 6; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (bus.mix_valid === 1'b1) lat = n;
        end
        checks++;
        if (lat != 13) begin errors++; $display("FAIL overrun_latency: got %0d expected 13", lat); end
        checks++;
        if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", bus.overrun); end
        @(posedge clk); #1;
        checks++;
        if (bus.mix_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", bus.mix_valid); end
        pulse_trig(7'd64, 11'd100);
        run_frame(1'b0, 7'd0, 11'd0);
        // Abort a frame 5 clocks in with asynchronous reset.
        @(negedge clk); bus.sample_en = 1'b1;
        @(negedge clk); bus.sample_en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mix_out !== 24'h0 || bus.voice_active !== 4'b0 || bus.overrun !== 1'b0 || bus.mix_valid !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: got %h/%b/%b/%b expected 000000/0000/0/0",
                               bus.mix_out, bus.voice_active, bus.overrun, bus.mix_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (bus.mix_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", seen); end
        run_frame(1'b0, 7'd0, 11'd0);
        checks++;
        if (bus.mix_out !== 24'h0) begin errors++; $display("FAIL post_abort_mix: got %h expected 000000", bus.mix_out); end
        $display("test_overrun_and_abort overrun=%b", bus.overrun);
    endtask

    initial begin
        rst           = 1'b1;
        bus.sample_en = 1'b0;
        bus.trig      = 1'b0;
        bus.velocity  = 7'd0;
        bus.delay_len = '0;
        bus.decay     = '0;
        bus.filt_mode = 2'd0;
        bus.noise     = '0;
        test_reset();
        test_idle_frames();
        test_decay_ring();
        test_round_robin();
        test_saturation();
        test_filter();
        test_silence();
        test_overrun_and_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
